// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings, slave state type and lane helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

    // Little-endian lane enables for an aligned transfer.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lane;
            HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_sram_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_mem
// Description : Word-organised SRAM, byte-enable synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : ahb_sram_mem
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite slave terminating transfers into on-chip SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int                   BUS_WIDTH   = 32,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   MEM_DEPTH   = 1024,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                   WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELx,
    input  logic [BUS_WIDTH-1:0]  HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int                 c_aw        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [BUS_WIDTH:0] c_mem_bytes = (BUS_WIDTH+1)'(MEM_DEPTH) << 2;

    slave_state_e         r_state;
    slave_state_e         w_state_nxt;
    logic [3:0]           r_cnt;
    logic [BUS_WIDTH-1:0] r_addr;
    logic [2:0]           r_size;
    logic                 r_write;
    logic                 r_valid;

    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_slot;
    logic                 w_we;
    logic [BUS_WIDTH-1:0] w_aoff;
    logic [BUS_WIDTH-1:0] w_roff;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_accept = HSELx & HREADY & HTRANS[1];
    assign w_aoff   = HADDR - BASE_ADDR;
    assign w_roff   = r_addr - BASE_ADDR;

    assign w_illegal = (HSIZE > 3'd2)
                     | ((HSIZE == HSIZE_HALF) & HADDR[0])
                     | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                     | (HADDR < BASE_ADDR)
                     | ({1'b0, w_aoff} >= c_mem_bytes);

    // Cycles in which a new address phase may be taken: idle, the completing
    // data cycle, or the second ERROR cycle.
    assign w_slot = (r_state == ST_IDLE) | (r_state == ST_ERR2)
                  | ((r_state == ST_DATA) & (r_cnt == 4'd0));

    assign w_we = (r_state == ST_DATA) & r_valid & r_write & (r_cnt == 4'd0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_ERR2, ST_DATA: begin
                if (w_slot) begin
                    if (w_accept) begin
                        w_state_nxt = w_illegal ? ST_ERR1 : ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        unique case (r_state)
            ST_DATA: begin
                HREADYOUT = (r_cnt == 4'd0);
                if (!r_write) begin
                    HRDATA = w_rdata;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_size  <= 3'd0;
            r_write <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_slot && w_accept) begin
            r_addr  <= HADDR;
            r_size  <= HSIZE;
            r_write <= HWRITE;
            r_valid <= ~w_illegal;
            r_cnt   <= 4'(WAIT_STATES);
        end else if ((r_state == ST_DATA) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else if (w_slot) begin
            r_valid <= 1'b0;
        end
    end

    ahb_sram_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (c_aw)
    ) u_mem (
        .clk     (HCLK),
        .i_we    (w_we),
        .i_be    (byte_en(r_size, r_addr[1:0])),
        .i_addr  (w_roff[c_aw+1:2]),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    // Burst type, HTRANS[0] and the non-index offset bits carry no meaning here.
    assign w_unused = ^{HBURST, HTRANS[0], w_roff};

endmodule : ahb_sram_slave
`default_nettype wire
